// File: rtl/adc_sar_sequencer.sv
// ---------------------------------------------------------------------------
// adc_sar_sequencer
//
// Successive-approximation ADC control sequencer. It runs a sampling phase,
// then does one binary-search step per bit, MSB first. Each step lets the
// capacitor-array DAC settle, fires the comparator once and waits for its
// decision. The bit is kept when the comparator reports that the input is
// above the DAC level.
//
// Parameters
//   NBITS          conversion width (DAC word width)
//   SAMPLE_CYCLES  sampling-phase length in clocks (1..15)
//   SETTLE_CYCLES  DAC settling clocks per bit (1..7)
//
// Ports
//   clk            single clock, rising edge
//   rst            synchronous active-high reset
//   start_in       conversion request, looked at only while idle
//   comp_in        comparator decision (1 = keep the bit under trial)
//   comp_valid_in  comparator decision strobe, looked at only while waiting
//   sample_out     sampling switch enable
//   comp_trig_out  one-cycle comparator trigger
//   dac_word_out   trial word to the row/column capacitor decoder
//   result_out     last completed conversion result
//   done_out       one-cycle conversion-complete pulse
//   busy_out       high whenever the sequencer is not idle
//
// Every output comes straight from a flop. The output flops are loaded from
// the *next* state, so each output lines up with the state it belongs to
// and there is no combinational path from an input to an output.
// ---------------------------------------------------------------------------
module adc_sar_sequencer #(
    parameter int NBITS         = 12,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic             comp_in,
    input  logic             comp_valid_in,
    output logic             sample_out,
    output logic             comp_trig_out,
    output logic [NBITS-1:0] dac_word_out,
    output logic [NBITS-1:0] result_out,
    output logic             done_out,
    output logic             busy_out
);

    localparam int IW = $clog2(NBITS);

    localparam logic [IW-1:0]    IDX_MSB     = IW'(NBITS - 1);
    localparam logic [IW-1:0]    IDX_ONE     = IW'(1);
    localparam logic [3:0]       SAMPLE_LOAD = 4'(SAMPLE_CYCLES - 1);
    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [NBITS-1:0] MSB_ONLY    = {1'b1, {(NBITS-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SAMPLE = 3'd1,
        S_SETTLE = 3'd2,
        S_TRIG   = 3'd3,
        S_WAIT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;        // remaining clocks in SAMPLE / SETTLE
    logic [IW-1:0]    idx_q, idx_d;        // bit currently under trial
    logic [NBITS-1:0] dac_q, dac_d;
    logic [NBITS-1:0] result_q, result_d;
    logic             sample_q, sample_d;
    logic             trig_q, trig_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    // Trial word after the comparator decision for the current bit has been
    // folded in. Bits below idx_q are zero in dac_q, so the only extra work
    // is to set the next trial bit.
    logic [NBITS-1:0] decided_word;

    // -----------------------------------------------------------------------
    // State and datapath register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= IDX_MSB;
            dac_q    <= '0;
            result_q <= '0;
            sample_q <= 1'b0;
            trig_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            dac_q    <= dac_d;
            result_q <= result_d;
            sample_q <= sample_d;
            trig_q   <= trig_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        dac_d        = dac_q;
        result_d     = result_q;

        decided_word = dac_q;
        decided_word[idx_q] = comp_in;
        if (idx_q != '0) begin
            decided_word[idx_q - IDX_ONE] = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                // dac_q keeps the last final word while idle.
                if (start_in) begin
                    state_d = S_SAMPLE;
                    cnt_d   = SAMPLE_LOAD;
                    dac_d   = '0;
                end
            end

            S_SAMPLE: begin
                if (cnt_q == '0) begin
                    state_d = S_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                    idx_d   = IDX_MSB;
                    dac_d   = MSB_ONLY;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_TRIG;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_TRIG: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (comp_valid_in) begin
                    dac_d = decided_word;
                    if (idx_q != '0) begin
                        idx_d   = idx_q - IDX_ONE;
                        cnt_d   = SETTLE_LOAD;
                        state_d = S_SETTLE;
                    end else begin
                        // Result is captured on the same edge that enters DONE.
                        result_d = decided_word;
                        state_d  = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic: decoded from the next state so that the registered
    // outputs are valid in the same cycle as the state they describe.
    // -----------------------------------------------------------------------
    always_comb begin
        sample_d = (state_d == S_SAMPLE);
        trig_d   = (state_d == S_TRIG);
        done_d   = (state_d == S_DONE);
        busy_d   = (state_d != S_IDLE);
    end

    assign sample_out    = sample_q;
    assign comp_trig_out = trig_q;
    assign dac_word_out  = dac_q;
    assign result_out    = result_q;
    assign done_out      = done_q;
    assign busy_out      = busy_q;

endmodule

// File: tb/tb_adc_sar_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adc_sar_sequencer
//
// Directed bench for adc_sar_sequencer with default parameters. A
// behavioural comparator answers each comp_trig_out pulse after a
// programmable delay. It can act as an ideal comparator against a given
// input code, or be tied to 1 or 0. It can also inject spurious strobes,
// which carry the wrong decision, in the SETTLE and TRIG cycles.
// ---------------------------------------------------------------------------
module tb_adc_sar_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_in = 1'b0;
    logic        comp_in = 1'b0;
    logic        comp_valid_in = 1'b0;
    logic        sample_out;
    logic        comp_trig_out;
    logic [11:0] dac_word_out;
    logic [11:0] result_out;
    logic        done_out;
    logic        busy_out;

    int checks = 0;
    int errors = 0;

    // Comparator model controls
    logic [11:0] vin = '0;
    int          mode = 0;      // 0 ideal, 1 tied high, 2 tied low
    int          dly = 1;       // strobe arrives dly cycles after the trigger cycle
    bit          spur_en = 1'b0;
    bit          pend = 1'b0;
    bit          extra = 1'b0;
    int          wcnt = 0;
    int          tn = 0;
    logic [11:0] trial [0:15];

    adc_sar_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start_in      (start_in),
        .comp_in       (comp_in),
        .comp_valid_in (comp_valid_in),
        .sample_out    (sample_out),
        .comp_trig_out (comp_trig_out),
        .dac_word_out  (dac_word_out),
        .result_out    (result_out),
        .done_out      (done_out),
        .busy_out      (busy_out)
    );

    always #5 clk = ~clk;

    function automatic logic decide();
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'b0;
        return (vin >= dac_word_out);
    endfunction

    // Comparator model, updated on falling edges away from the DUT edge.
    always @(negedge clk) begin
        if (comp_valid_in) begin
            if (extra) begin
                comp_in = ~comp_in;   // wrong decision held into SETTLE
                extra   = 1'b0;
            end else begin
                comp_valid_in = 1'b0;
            end
        end
        if (!busy_out) begin
            pend = 1'b0;
            tn   = 0;
        end
        if (pend) begin
            if (wcnt == 0) begin
                comp_valid_in = 1'b1;
                comp_in       = decide();
                extra         = spur_en;
                if (tn < 16) trial[tn] = dac_word_out;
                tn   = tn + 1;
                pend = 1'b0;
            end else begin
                wcnt = wcnt - 1;
            end
        end
        if (comp_trig_out) begin
            pend = 1'b1;
            wcnt = dly - 1;
            if (spur_en) begin
                comp_valid_in = 1'b1;
                comp_in       = ~decide();
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One conversion from idle. lat is the number of rising edges between
    // the edge that samples start_in and the edge that raises done_out.
    task automatic do_conv(input logic [11:0] v, input int md, input int d, input bit sp,
                           output logic [11:0] res, output int lat, output int trigs);
        vin = v; mode = md; dly = d; spur_en = sp;
        @(negedge clk); start_in = 1'b1;
        @(posedge clk);
        @(negedge clk); start_in = 1'b0;
        lat = 0; trigs = 0;
        while (lat < 3000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (comp_trig_out) trigs++;
            if (done_out) break;
        end
        res = result_out;
        @(negedge clk);
        check("done_single_pulse", {31'b0, done_out}, 32'd0);
    endtask

    logic [11:0] res;
    int          lat, trigs, n, idle_cnt, done_seen;

    initial begin
        // Power-on reset
        repeat (3) @(negedge clk);
        check("rst_sample",  {31'b0, sample_out},    32'd0);
        check("rst_trig",    {31'b0, comp_trig_out}, 32'd0);
        check("rst_dac",     {20'b0, dac_word_out},  32'd0);
        check("rst_result",  {20'b0, result_out},    32'd0);
        check("rst_done",    {31'b0, done_out},      32'd0);
        check("rst_busy",    {31'b0, busy_out},      32'd0);
        rst = 1'b0;

        // Ideal comparator, Vin = 2730
        do_conv(12'd2730, 0, 1, 1'b0, res, lat, trigs);
        $display("conv vin=2730 ideal: result=%h latency=%0d trigs=%0d", res, lat, trigs);
        check("ideal_result",  {20'b0, res}, 32'h0000_0AAA);
        check("ideal_latency", lat,   40);
        check("ideal_trigs",   trigs, 12);
        check("idle_dac_hold", {20'b0, dac_word_out}, 32'h0000_0AAA);
        check("idle_busy",     {31'b0, busy_out}, 32'd0);

        // Comparator tied high / low
        do_conv(12'd0, 1, 1, 1'b0, res, lat, trigs);
        $display("conv tied1: result=%h latency=%0d", res, lat);
        check("tie1_result", {20'b0, res}, 32'h0000_0FFF);
        check("tie1_latency", lat, 40);
        do_conv(12'd0, 2, 1, 1'b0, res, lat, trigs);
        $display("conv tied0: result=%h latency=%0d", res, lat);
        check("tie0_result", {20'b0, res}, 32'h0000_0000);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("tie0_trial%0d", i), {20'b0, trial[i]}, 32'h800 >> i);
        end

        // Delayed strobes plus spurious strobes in SETTLE/TRIG
        do_conv(12'd1234, 0, 5, 1'b1, res, lat, trigs);
        $display("conv vin=1234 delay5 spurious: result=%h latency=%0d", res, lat);
        check("spur_result",  {20'b0, res}, 32'd1234);
        check("spur_latency", lat, 88);
        spur_en = 1'b0;

        // Reset while waiting on bit 5
        vin = 12'd2730; mode = 0; dly = 5;
        @(negedge clk); start_in = 1'b1;
        @(negedge clk); start_in = 1'b0;
        n = 0;
        for (int c = 0; c < 500 && n < 7; c++) begin
            @(negedge clk);
            if (comp_trig_out) n++;
        end
        check("rst_reach_bit5", n, 7);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("midrst_sample", {31'b0, sample_out},    32'd0);
        check("midrst_trig",   {31'b0, comp_trig_out}, 32'd0);
        check("midrst_dac",    {20'b0, dac_word_out},  32'd0);
        check("midrst_result", {20'b0, result_out},    32'd0);
        check("midrst_done",   {31'b0, done_out},      32'd0);
        check("midrst_busy",   {31'b0, busy_out},      32'd0);
        done_seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done_out || busy_out) done_seen++;
        end
        $display("reset in WAIT bit5: activity after reset=%0d", done_seen);
        check("midrst_quiet", done_seen, 0);
        do_conv(12'd1365, 0, 1, 1'b0, res, lat, trigs);
        $display("conv after reset vin=1365: result=%h latency=%0d", res, lat);
        check("post_rst_result", {20'b0, res}, 32'd1365);

        // start_in pulsed during WAIT and during DONE is ignored
        vin = 12'd3000; mode = 0; dly = 5;
        @(negedge clk); start_in = 1'b1;
        @(negedge clk); start_in = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (comp_trig_out) break;
        end
        @(negedge clk); start_in = 1'b1;   // in WAIT
        @(negedge clk); start_in = 1'b0;
        n = 0;
        while (n < 1000 && !done_out) begin
            @(negedge clk);
            n++;
        end
        check("wait_start_done_seen", {31'b0, done_out}, 32'd1);
        start_in = 1'b1;                    // in DONE
        @(negedge clk); start_in = 1'b0;
        check("done_start_busy0", {31'b0, busy_out}, 32'd0);
        @(negedge clk);
        check("done_start_busy1", {31'b0, busy_out}, 32'd0);
        $display("start pulses in WAIT/DONE: result=%h", result_out);
        check("ignored_start_result", {20'b0, result_out}, 32'd3000);

        // start_in held high: back-to-back conversions
        vin = 12'd100; mode = 0; dly = 1;
        @(negedge clk); start_in = 1'b1;
        n = 0;
        while (n < 200 && !done_out) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_done", {31'b0, done_out}, 32'd1);
        check("b2b_first_result", {20'b0, result_out}, 32'd100);
        idle_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (!busy_out) idle_cnt++;
        end
        $display("back-to-back: idle cycles between conversions=%0d", idle_cnt);
        check("b2b_idle_cycles", idle_cnt, 1);
        vin = 12'd4000;
        n = 0;
        while (n < 200 && !done_out) begin
            @(negedge clk);
            n++;
        end
        start_in = 1'b0;
        check("b2b_second_result", {20'b0, result_out}, 32'd4000);
        repeat (3) @(negedge clk);

        // Code sweep
        for (int v = 0; v < 4096; v += 65) begin
            do_conv(12'(v), 0, 1, 1'b0, res, lat, trigs);
            $display("sweep vin=%0d result=%0d", v, res);
            check($sformatf("sweep_%0d", v), {20'b0, res}, 32'(v));
        end
        do_conv(12'd4095, 0, 1, 1'b0, res, lat, trigs);
        $display("sweep vin=4095 result=%0d", res);
        check("sweep_4095", {20'b0, res}, 32'd4095);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_sar_sequencer.md
ADC_SAR_SEQUENCER -- requirements
Module: adc_sar_sequencer

Interface
REQ-001 Parameter NBITS, 12, conversion width; sized for the 12-bit DAC word of the row/column capacitor-array decoder.
REQ-002 Parameter SAMPLE_CYCLES, 4, sampling-phase length in clocks (legal 1..15).
REQ-003 Parameter SETTLE_CYCLES, 1, DAC settling clocks per bit (legal 1..7).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 start_in  input  1  conversion request; sampled only in IDLE.
REQ-007 comp_in  input  1  comparator decision; 1 = input above DAC level (keep bit).
REQ-008 comp_valid_in  input  1  comparator-decision-ready strobe.
REQ-009 sample_out  output  1  sampling switch enable.
REQ-010 comp_trig_out  output  1  one-cycle comparator trigger.
REQ-011 dac_word_out  output  NBITS  trial word driven to the row/column decoder data input.
REQ-012 result_out  output  NBITS  last completed conversion result.
REQ-013 done_out  output  1  one-cycle conversion-complete pulse.
REQ-014 busy_out  output  1  high in every state except IDLE.

Function
REQ-015 States: IDLE, SAMPLE, SETTLE, TRIG, WAIT, DONE; no other reachable states.
REQ-016 IDLE: start_in=1 -> SAMPLE; else stay.
REQ-017 SAMPLE: sample_out=1, dac_word_out=0; held exactly SAMPLE_CYCLES clocks -> SETTLE with dac_word_out=MSB-only (12'h800), bit index=NBITS-1.
REQ-018 SETTLE: held exactly SETTLE_CYCLES clocks, dac_word_out stable -> TRIG.
REQ-019 TRIG: comp_trig_out=1 for exactly this one cycle -> WAIT.
REQ-020 WAIT: stay until comp_valid_in=1; no timeout.
REQ-021 On comp_valid_in in WAIT: bit[index] <= comp_in; if index>0, bit[index-1] <= 1, index decrements, -> SETTLE; if index=0 -> DONE.
REQ-022 DONE: result_out <= final word (same edge as DONE entry), done_out=1 for this single cycle -> IDLE.
REQ-023 comp_valid_in outside WAIT and comp_in when comp_valid_in=0 are ignored.
REQ-024 start_in while busy_out=1 (including DONE) is ignored; not queued.
REQ-025 start_in held high continuously: back-to-back conversions, new SAMPLE starts cycle after DONE.
REQ-026 dac_word_out holds last final word in IDLE; bits below current index are always 0 during SETTLE/TRIG/WAIT.
REQ-027 result_out changes only on DONE entry; stable otherwise.
REQ-028 Latency (defaults, comp_valid_in high in first WAIT cycle): done_out high 40 rising edges after the edge sampling start_in; 3 clocks per bit.
REQ-029 All outputs registered; no combinational path input -> output.

Reset
REQ-030 rst=1 at any clock edge, including mid-conversion: state=IDLE, sample_out=0, comp_trig_out=0, dac_word_out=0, result_out=0, done_out=0, busy_out=0, bit index=NBITS-1.
REQ-031 rst has priority over start_in and comp_valid_in in the same cycle; no done_out pulse for an aborted conversion.

Verification
REQ-032 Ideal comparator model, Vin code 2730, comp_valid_in one cycle after comp_trig_out -> result_out=12'hAAA, done_out single pulse at edge 40, 12 comp_trig_out pulses.
REQ-033 comp_in tied 1 -> result_out=12'hFFF; comp_in tied 0 -> result_out=12'h000; dac_word_out trial sequence 800,400,...,001 in the all-0 case.
REQ-034 comp_valid_in delayed 5 cycles each bit, plus spurious comp_valid_in pulses in SETTLE/TRIG -> spurious ignored, result correct, total latency grows by 48 clocks.
REQ-035 rst asserted in WAIT of bit 5 -> next cycle all outputs at reset values, no done_out; fresh start -> correct result.
REQ-036 start_in pulsed during WAIT and during DONE -> ignored; start_in held high -> back-to-back conversions, busy_out low for exactly one IDLE cycle between them.
REQ-037 Sweep Vin 0..4095 with ideal model -> result_out equals Vin for every code.
